// File: rtl/hazard_stall_unit_pkg.sv
// Shared hazard-unit definitions, also imported by the instruction decoder.
// Contents:
//   - Tuse / Tnew encodings (2-bit; TUSE_NONE marks an unused source)
//   - forward-select constants FWD_RF / FWD_E / FWD_M / FWD_W
//   - the register-zero index
//   - shadow_t: the (A3, Tnew) pair tracked per pipeline stage
//   - dec_tnew(): saturating decrement applied as a result moves down a stage
package hazard_stall_unit_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;
  typedef logic [1:0] fwd_sel_t;

  localparam tuse_t TUSE_0    = 2'd0;
  localparam tuse_t TUSE_1    = 2'd1;
  localparam tuse_t TUSE_2    = 2'd2;
  localparam tuse_t TUSE_NONE = 2'd3;

  localparam tnew_t TNEW_0 = 2'd0;
  localparam tnew_t TNEW_1 = 2'd1;
  localparam tnew_t TNEW_2 = 2'd2;
  localparam tnew_t TNEW_3 = 2'd3;

  localparam fwd_sel_t FWD_RF = 2'd0;
  localparam fwd_sel_t FWD_E  = 2'd1;
  localparam fwd_sel_t FWD_M  = 2'd2;
  localparam fwd_sel_t FWD_W  = 2'd3;

  localparam reg_idx_t REG_ZERO = 5'd0;

  localparam int unsigned MD_CNT_W = 4;

  typedef struct packed {
    reg_idx_t a3;
    tnew_t    tnew;
  } shadow_t;

  // Saturating decrement: a result that is already available stays available.
  function automatic tnew_t dec_tnew(input tnew_t x);
    return (x == TNEW_0) ? TNEW_0 : x - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle between the decoder/datapath side (master) and the hazard unit (slave).
//   master drives: flush, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_Tnew, D_A3,
//                  D_isMD, md_start, md_is_div
//   slave drives:  stall, md_busy, fwd_rs, fwd_rt
interface hazard_stall_unit_if;
  import hazard_stall_unit_pkg::*;

  logic     flush;
  reg_idx_t D_rs;
  reg_idx_t D_rt;
  tuse_t    D_Tuse_rs;
  tuse_t    D_Tuse_rt;
  tnew_t    D_Tnew;
  reg_idx_t D_A3;
  logic     D_isMD;
  logic     md_start;
  logic     md_is_div;
  logic     stall;
  logic     md_busy;
  fwd_sel_t fwd_rs;
  fwd_sel_t fwd_rt;

  modport master (
    output flush, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_Tnew, D_A3, D_isMD,
           md_start, md_is_div,
    input  stall, md_busy, fwd_rs, fwd_rt
  );

  modport slave (
    input  flush, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_Tnew, D_A3, D_isMD,
           md_start, md_is_div,
    output stall, md_busy, fwd_rs, fwd_rt
  );

endinterface

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Mult/div busy counter.
// Ports:
//   clk       in  rising-edge clock
//   reset     in  synchronous, active-low reset
//   md_start  in  one-cycle pulse: a mult/div is in E this cycle
//   md_is_div in  qualifies md_start (1 = div/divu, 0 = mult/multu)
//   md_busy   out counter is nonzero
// The counter is deliberately not cleared by a pipeline flush: the operation
// has already been issued to the multiplier and will run to completion.
module md_busy_counter
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (md_start) begin
      cnt_d = md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy = (cnt_q != '0);

  // A new mult/div while one is still running would silently restart the count.
  md_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(md_start && md_busy)
  );

endmodule

// File: rtl/hazard_stall_unit.sv
// D-stage stall and forward-select generation.
// Tracks a shadow copy of (A3, Tnew) for the E, M and W stages and compares
// it against the Tuse/rs/rt of the instruction currently in D.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-low reset
//   bus    slave side of hazard_stall_unit_if (D-stage decode info, flush,
//          md_start/md_is_div in; stall, md_busy, fwd_rs, fwd_rt out)
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_stall_unit_if.slave   bus
);

  shadow_t  e_q, m_q, w_q;
  shadow_t  e_d, m_d, w_d;
  logic     md_busy;
  logic     stall_c;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk       (clk),
    .reset     (reset),
    .md_start  (bus.md_start),
    .md_is_div (bus.md_is_div),
    .md_busy   (md_busy)
  );

  // The source is needed (tuse) before the producer at this stage has it (tnew).
  function automatic logic raw_hazard(input reg_idx_t src, input tuse_t tuse,
                                      input shadow_t st);
    return (src != REG_ZERO) && (src == st.a3) && (tuse < st.tnew);
  endfunction

  // Youngest stage whose result is already available wins.
  function automatic fwd_sel_t fwd_pick(input reg_idx_t src, input shadow_t e,
                                        input shadow_t m, input shadow_t w);
    if (src == REG_ZERO)                        return FWD_RF;
    if ((src == e.a3) && (e.tnew == TNEW_0))    return FWD_E;
    if ((src == m.a3) && (m.tnew == TNEW_0))    return FWD_M;
    if ((src == w.a3) && (w.tnew == TNEW_0))    return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    stall_c = raw_hazard(bus.D_rs, bus.D_Tuse_rs, e_q) ||
              raw_hazard(bus.D_rs, bus.D_Tuse_rs, m_q) ||
              raw_hazard(bus.D_rt, bus.D_Tuse_rt, e_q) ||
              raw_hazard(bus.D_rt, bus.D_Tuse_rt, m_q) ||
              (bus.D_isMD && (md_busy || bus.md_start));
  end

  always_comb begin
    e_d = '0;
    m_d = '0;
    w_d = '0;
    // On stall the instruction stays in D and a bubble enters E.
    if (!stall_c) begin
      e_d.a3   = bus.D_A3;
      e_d.tnew = dec_tnew(bus.D_Tnew);
    end
    m_d.a3   = e_q.a3;
    m_d.tnew = dec_tnew(e_q.tnew);
    w_d.a3   = m_q.a3;
    w_d.tnew = dec_tnew(m_q.tnew);
  end

  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign bus.stall   = stall_c;
  assign bus.md_busy = md_busy;
  assign bus.fwd_rs  = fwd_pick(bus.D_rs, e_q, m_q, w_q);
  assign bus.fwd_rt  = fwd_pick(bus.D_rt, e_q, m_q, w_q);

endmodule
